// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: execute-stage branch resolution with a 2-bit counter BHT and perf counters.
module branch_predict_resolve #(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W = $clog2(BHT_ENTRIES),
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   fetch_pc_i,
  output logic              pred_taken_o,
  input  logic              ex_valid_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic [XLEN-1:0]   in1_i,
  input  logic [XLEN-1:0]   in2_i,
  input  logic [2:0]        bj_sel_i,
  input  logic              ex_pred_taken_i,
  output logic              PC_sel_o,
  output logic              mispredict_o,
  output logic              res_valid_o,
  output logic [PERF_W-1:0] branch_cnt_o,
  output logic [PERF_W-1:0] mispredict_cnt_o
);
  logic [1:0] r_bht [BHT_ENTRIES];
  logic r_pc_sel, r_mispredict, r_res_valid;
  logic [PERF_W-1:0] r_branch_cnt, r_mispredict_cnt;
  logic w_eq, w_lts, w_ltu, w_taken, w_acc, w_cond, w_mis, w_unused;
  logic [7:0] w_dec;
  logic [IDX_W-1:0] w_fidx, w_eidx;
  logic [1:0] w_cur;
  assign w_eq  = in1_i == in2_i;
  assign w_lts = $signed(in1_i) < $signed(in2_i);
  assign w_ltu = in1_i < in2_i;
  // bit n of w_dec is the outcome for bj_sel_i == n
  assign w_dec   = {~w_ltu, w_ltu, ~w_lts, w_lts, 1'b1, 1'b0, ~w_eq, w_eq};
  assign w_taken = w_dec[bj_sel_i];
  assign w_acc   = ex_valid_i & ~flush_i;
  assign w_cond  = bj_sel_i[2] | ~bj_sel_i[1];
  assign w_mis   = w_taken ^ ex_pred_taken_i;
  assign w_fidx  = fetch_pc_i[IDX_W+1:2];
  assign w_eidx  = ex_pc_i[IDX_W+1:2];
  assign w_cur   = r_bht[w_eidx];
  assign pred_taken_o = r_bht[w_fidx][1];
  assign w_unused = ^{fetch_pc_i, ex_pc_i};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= INIT_STATE;
      r_pc_sel <= 1'b0;
      r_mispredict <= 1'b0;
      r_res_valid <= 1'b0;
      r_branch_cnt <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_res_valid <= w_acc;
      r_mispredict <= w_acc & w_mis;
      if (w_acc) r_pc_sel <= w_taken;
      if (w_acc && w_cond)
        r_bht[w_eidx] <= w_taken ? ((&w_cur) ? w_cur : w_cur + 2'd1)
                                 : ((|w_cur) ? w_cur - 2'd1 : w_cur);
      if (w_acc && w_cond && ~&r_branch_cnt) r_branch_cnt <= r_branch_cnt + PERF_W'(1);
      if (w_acc && w_mis && ~&r_mispredict_cnt) r_mispredict_cnt <= r_mispredict_cnt + PERF_W'(1);
    end
  end
  assign PC_sel_o = r_pc_sel;
  assign mispredict_o = r_mispredict;
  assign res_valid_o = r_res_valid;
  assign branch_cnt_o = r_branch_cnt;
  assign mispredict_cnt_o = r_mispredict_cnt;
endmodule
